eth_mii_frame_tx: RTL

ETH_MII_FRAME_TX -- requirements
Module: eth_mii_frame_tx

---
 rtl/eth_mii_frame_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/eth_mii_frame_tx.sv
// Streams fixed-header Ethernet frames onto a 25 MHz MII interface. Payload bytes
// are pulled from a standard-mode FIFO one slot ahead, and the frame ends with a CRC-32 FCS.
module eth_mii_frame_tx #(
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC     = 48'h00_0A_35_00_01_02,
  parameter logic [15:0] ETH_TYPE    = 16'h88B5,
  parameter int          PAYLOAD_LEN = 64,
  parameter int          IFG_BYTES   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  input  logic       fifo_prog_empty,
  output logic       fifo_rd_en,
  output logic [3:0] mii_txd,
  output logic       mii_tx_en,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow,
  output logic [2:0] dbg_state
);

  localparam int CNT_MAX = (PAYLOAD_LEN > IFG_BYTES) ? PAYLOAD_LEN : IFG_BYTES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [111:0] HDR = {DST_MAC, SRC_MAC, ETH_TYPE};

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_HEADER, S_PAYLOAD, S_FCS, S_IFG
  } state_t;

  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   crc_q, crc_d;
  logic [7:0]    next_byte_q, next_byte_d;
  logic          fill_q, fill_d, cap_q, cap_d, got_q, got_d;
  logic          rd_en_q, rd_en_d;
  logic [3:0]    txd_q, txd_d;
  logic          tx_en_q, tx_en_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;
  logic          underflow_q, underflow_d;

  logic [CW-1:0] slot_last;
  logic [7:0]    cur_byte;
  logic [111:0]  hdr_sh;
  logic [31:0]   fcs_sh;
  logic          read_due;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    slot_last = '0;
    hdr_sh    = HDR << {cnt_q, 3'b000};
    fcs_sh    = ~crc_q >> {cnt_q, 3'b000};
    cur_byte  = 8'h00;
    case (state_q)
      S_PREAMBLE: begin slot_last = CW'(6);             cur_byte = 8'h55;          end
      S_SFD:      begin slot_last = CW'(0);             cur_byte = 8'hD5;          end
      S_HEADER:   begin slot_last = CW'(13);            cur_byte = hdr_sh[111:104]; end
      S_PAYLOAD:  begin slot_last = CW'(PAYLOAD_LEN-1); cur_byte = next_byte_q;     end
      S_FCS:      begin slot_last = CW'(3);             cur_byte = fcs_sh[7:0];     end
      S_IFG:      begin slot_last = CW'(IFG_BYTES-1);                               end
      default:    ;
    endcase
  end

  // A read is decided two cycles before the byte is needed: rd_en goes out on the
  // phase-0 cycle of the preceding slot and the data is captured on its phase-1 cycle.
  assign read_due = phase_q &&
                    (((state_q == S_HEADER) && (cnt_q >= CW'(12))) ||
                     ((state_q == S_PAYLOAD) && (cnt_q <= CW'(PAYLOAD_LEN-3))));

  always_comb begin
    state_d      = state_q;
    phase_d      = ~phase_q;
    cnt_d        = cnt_q;
    crc_d        = crc_q;
    next_byte_d  = next_byte_q;
    fill_d       = read_due;
    rd_en_d      = read_due && !fifo_empty;
    cap_d        = fill_q;
    got_d        = rd_en_q;
    underflow_d  = underflow_q | (read_due & fifo_empty);
    tx_en_d      = 1'b0;
    txd_d        = 4'h0;
    frame_done_d = (state_q == S_FCS) && phase_q && (cnt_q == CW'(3));

    if (cap_q) next_byte_d = got_q ? fifo_dout : 8'h00;

    if (state_q == S_IDLE) begin
      phase_d = 1'b0;
      cnt_d   = '0;
      crc_d   = 32'hFFFF_FFFF;
      if (!fifo_prog_empty) state_d = S_PREAMBLE;
    end else begin
      if (phase_q && ((state_q == S_HEADER) || (state_q == S_PAYLOAD)))
        crc_d = crc32_byte(crc_q, cur_byte);
      if (phase_q) begin
        if (cnt_q == slot_last) begin
          cnt_d = '0;
          case (state_q)
            S_PREAMBLE: state_d = S_SFD;
            S_SFD:      state_d = S_HEADER;
            S_HEADER:   state_d = S_PAYLOAD;
            S_PAYLOAD:  state_d = S_FCS;
            S_FCS:      state_d = S_IFG;
            default:    state_d = S_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    if ((state_q != S_IDLE) && (state_q != S_IFG)) begin
      tx_en_d = 1'b1;
      txd_d   = phase_q ? cur_byte[7:4] : cur_byte[3:0];
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      cnt_q        <= '0;
      crc_q        <= 32'hFFFF_FFFF;
      next_byte_q  <= 8'h00;
      fill_q       <= 1'b0;
      cap_q        <= 1'b0;
      got_q        <= 1'b0;
      rd_en_q      <= 1'b0;
      txd_q        <= 4'h0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      crc_q        <= crc_d;
      next_byte_q  <= next_byte_d;
      fill_q       <= fill_d;
      cap_q        <= cap_d;
      got_q        <= got_d;
      rd_en_q      <= rd_en_d;
      txd_q        <= txd_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underflow_q  <= underflow_d;
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign mii_txd    = txd_q;
  assign mii_tx_en  = tx_en_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underflow  = underflow_q;
  assign dbg_state  = state_q;

endmodule
